// File: rtl/pingpong_sched.sv
// Ping-pong buffer scheduler: swaps reader/writer buffers at frame boundaries once the inactive one is loaded.
// Optional `PINGPONG_SCHED_LOOP_LIMIT_EN adds a loop_limit input that ends playback after N frames.
module pingpong_sched #(
  parameter int unsigned FRAME_CNT_W = 16,
  parameter int unsigned SWAP_GAP    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   repeat_mode,
  input  logic                   wr_done,
  input  logic                   frame_end,
`ifdef PINGPONG_SCHED_LOOP_LIMIT_EN
  input  logic [FRAME_CNT_W-1:0] loop_limit,
`endif
  output logic                   active_buffer,
  output logic                   wen,
  output logic                   ren,
  output logic                   busy,
  output logic                   pending,
  output logic                   underflow,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRELOAD = 2'd1;
  localparam logic [1:0] SWAP    = 2'd2;
  localparam logic [1:0] RUN     = 2'd3;

  // Counter is loaded with GAP-1 so that exactly SWAP_GAP cycles pass with ren=0.
  localparam logic [3:0] GAP_LOAD = 4'(SWAP_GAP - 1);

  logic [1:0]             state, state_n;
  logic [3:0]             gap_cnt, gap_n;
  logic                   stop_req, stop_req_n;
  logic                   act_n, pend_n, unf_n;
  logic                   wen_n, ren_n, busy_n;
  logic [FRAME_CNT_W-1:0] cnt_n, cnt_inc;
  logic                   limit_hit;

  always_comb begin
    state_n    = state;
    gap_n      = gap_cnt;
    stop_req_n = stop_req;
    act_n      = active_buffer;
    pend_n     = pending;
    unf_n      = underflow;
    cnt_n      = frame_cnt;
    cnt_inc    = frame_cnt + 1'b1;
`ifdef PINGPONG_SCHED_LOOP_LIMIT_EN
    limit_hit  = (loop_limit != '0) && (cnt_inc == loop_limit);
`else
    limit_hit  = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = PRELOAD;
          unf_n      = 1'b0;
          cnt_n      = '0;
          pend_n     = 1'b0;
          stop_req_n = 1'b0;
        end
      end
      PRELOAD: begin
        if (stop) begin
          state_n = IDLE;
        end else if (wr_done) begin
          act_n   = ~active_buffer;
          state_n = SWAP;
          gap_n   = GAP_LOAD;
        end
      end
      SWAP: begin
        if (stop) stop_req_n = 1'b1;
        if (gap_cnt == '0) state_n = RUN;
        else               gap_n   = gap_cnt - 1'b1;
      end
      RUN: begin
        if (stop) stop_req_n = 1'b1;
        if (frame_end) begin
          cnt_n = cnt_inc;
          if (stop_req || limit_hit) begin
            state_n    = IDLE;
            stop_req_n = 1'b0;
            if (wr_done) pend_n = 1'b1;
          end else if (pending || wr_done) begin
            act_n   = ~active_buffer;
            pend_n  = 1'b0;
            state_n = SWAP;
            gap_n   = GAP_LOAD;
          end else if (repeat_mode) begin
            unf_n = 1'b1;
          end else begin
            unf_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (wr_done) begin
          pend_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Enables are registered from the next state so they line up with it.
    wen_n  = (state_n == PRELOAD) || ((state_n == RUN) && !pend_n);
    ren_n  = (state_n == RUN);
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      stop_req      <= 1'b0;
      active_buffer <= 1'b0;
      wen           <= 1'b0;
      ren           <= 1'b0;
      busy          <= 1'b0;
      pending       <= 1'b0;
      underflow     <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state         <= state_n;
      gap_cnt       <= gap_n;
      stop_req      <= stop_req_n;
      active_buffer <= act_n;
      wen           <= wen_n;
      ren           <= ren_n;
      busy          <= busy_n;
      pending       <= pend_n;
      underflow     <= unf_n;
      frame_cnt     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_pingpong_sched.sv
// Bench for pingpong_sched: table of per-cycle vectors plus hand sequences, checked through a scoreboard queue.
module tb_pingpong_sched;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, repeat_mode = 1'b0, wr_done = 1'b0, frame_end = 1'b0;
  logic active_buffer, wen, ren, busy, pending, underflow;
  logic [W-1:0] frame_cnt;
`ifdef PINGPONG_SCHED_LOOP_LIMIT_EN
  logic [W-1:0] loop_limit = '0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic act, wen, ren, busy, pend, unf;
    logic [W-1:0] cnt;
  } out_t;

  typedef struct {
    logic s, sp, rp, wd, fe;
    out_t exp;
  } vec_t;

  out_t sb[$];
  vec_t tbl[18];

  always #5 clk = ~clk;

  pingpong_sched #(.FRAME_CNT_W(W), .SWAP_GAP(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .repeat_mode(repeat_mode),
    .wr_done(wr_done), .frame_end(frame_end),
`ifdef PINGPONG_SCHED_LOOP_LIMIT_EN
    .loop_limit(loop_limit),
`endif
    .active_buffer(active_buffer), .wen(wen), .ren(ren), .busy(busy),
    .pending(pending), .underflow(underflow), .frame_cnt(frame_cnt)
  );

  function automatic out_t o(input logic a, w, r, b, p, u, input logic [W-1:0] c);
    out_t x;
    x = {a, w, r, b, p, u, c};
    return x;
  endfunction

  function automatic vec_t mk(input logic s, sp, rp, wd, fe, input out_t e);
    vec_t v;
    v.s = s; v.sp = sp; v.rp = rp; v.wd = wd; v.fe = fe; v.exp = e;
    return v;
  endfunction

  task automatic check_now(input string name);
    out_t a, e;
    a = {active_buffer, wen, ren, busy, pending, underflow, frame_cnt};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got act=%b wen=%b ren=%b busy=%b pend=%b unf=%b cnt=%0d, want act=%b wen=%b ren=%b busy=%b pend=%b unf=%b cnt=%0d",
                 name, a.act, a.wen, a.ren, a.busy, a.pend, a.unf, a.cnt,
                 e.act, e.wen, e.ren, e.busy, e.pend, e.unf, e.cnt);
      end
    end
  endtask

  task automatic step(input string name, input logic s, sp, rp, wd, fe, input out_t e);
    @(negedge clk);
    start = s; stop = sp; repeat_mode = rp; wr_done = wd; frame_end = fe;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_now(name);
  endtask

  task automatic check_zero(input string name);
    logic [W+5:0] a;
    a = {active_buffer, wen, ren, busy, pending, underflow, frame_cnt};
    checks++;
    if (a !== '0) begin
      errors++;
      $display("FAIL %s: got outputs %b, want all zero", name, a);
    end
  endtask

  initial begin
    // Main table: inputs during the cycle, outputs expected right after the edge.
    tbl[0]  = mk(1,0,0,0,0, o(0,1,0,1,0,0,0));
    tbl[1]  = mk(0,0,0,0,0, o(0,1,0,1,0,0,0));
    tbl[2]  = mk(0,0,0,1,0, o(1,0,0,1,0,0,0));
    tbl[3]  = mk(0,0,0,0,0, o(1,0,0,1,0,0,0));
    tbl[4]  = mk(0,0,0,0,0, o(1,1,1,1,0,0,0));
    tbl[5]  = mk(0,0,0,1,0, o(1,0,1,1,1,0,0));
    tbl[6]  = mk(0,0,0,1,0, o(1,0,1,1,1,0,0));
    tbl[7]  = mk(0,0,0,0,1, o(0,0,0,1,0,0,1));
    tbl[8]  = mk(0,0,0,0,1, o(0,0,0,1,0,0,1));
    tbl[9]  = mk(0,0,0,0,0, o(0,1,1,1,0,0,1));
    tbl[10] = mk(0,0,0,1,1, o(1,0,0,1,0,0,2));
    tbl[11] = mk(0,0,0,0,0, o(1,0,0,1,0,0,2));
    tbl[12] = mk(0,0,0,0,0, o(1,1,1,1,0,0,2));
    tbl[13] = mk(0,0,1,0,1, o(1,1,1,1,0,1,3));
    tbl[14] = mk(0,0,0,0,1, o(1,0,0,0,0,1,4));
    tbl[15] = mk(0,1,0,0,0, o(1,0,0,0,0,1,4));
    tbl[16] = mk(1,1,0,0,0, o(1,1,0,1,0,0,0));
    tbl[17] = mk(0,1,0,0,0, o(1,0,0,0,0,0,0));

    #1 rst = 1'b0;
    #2 check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++)
      step($sformatf("table[%0d]", i), tbl[i].s, tbl[i].sp, tbl[i].rp, tbl[i].wd, tbl[i].fe, tbl[i].exp);

    // Stop mid-frame, frame_end long afterwards; pending survives the stop.
    step("stopA_start",   1,0,0,0,0, o(1,1,0,1,0,0,0));
    step("stopA_wrdone",  0,0,0,1,0, o(0,0,0,1,0,0,0));
    step("stopA_gap",     0,0,0,0,0, o(0,0,0,1,0,0,0));
    step("stopA_run",     0,0,0,0,0, o(0,1,1,1,0,0,0));
    step("stopA_pend",    0,0,0,1,0, o(0,0,1,1,1,0,0));
    step("stopA_stop",    0,1,0,0,0, o(0,0,1,1,1,0,0));
    for (int i = 0; i < 50; i++)
      step("stopA_wait",  0,0,0,0,0, o(0,0,1,1,1,0,0));
    step("stopA_fe",      0,0,0,0,1, o(0,0,0,0,1,0,1));
    step("stopA_restart", 1,0,0,0,0, o(0,1,0,1,0,0,0));
    step("stop_preload",  0,1,0,0,0, o(0,0,0,0,0,0,0));

    // Stop during SWAP is remembered and beats repeat at the next frame_end.
    step("stopB_start",   1,0,0,0,0, o(0,1,0,1,0,0,0));
    step("stopB_wrdone",  0,0,0,1,0, o(1,0,0,1,0,0,0));
    step("stopB_swapstop",0,1,0,0,0, o(1,0,0,1,0,0,0));
    step("stopB_run",     0,0,0,0,0, o(1,1,1,1,0,0,0));
    step("stopB_fe",      0,0,1,0,1, o(1,0,0,0,0,0,1));

    // Repeat-mode underflow every cycle: frame_cnt wraps past all-ones.
    step("wrap_start",    1,0,0,0,0, o(1,1,0,1,0,0,0));
    step("wrap_wrdone",   0,0,0,1,0, o(0,0,0,1,0,0,0));
    step("wrap_gap",      0,0,0,0,0, o(0,0,0,1,0,0,0));
    step("wrap_run",      0,0,0,0,0, o(0,1,1,1,0,0,0));
    for (int k = 1; k <= 17; k++) begin
      logic [W-1:0] c;
      c = W'(k);
      step($sformatf("wrap_fe%0d", k), 0,0,1,0,1, o(0,1,1,1,0,1,c));
    end
    step("wrap_stop",     0,1,1,0,0, o(0,1,1,1,0,1,1));
    step("wrap_fe_end",   0,0,1,0,1, o(0,0,0,0,0,1,2));

    // Asynchronous reset while in SWAP.
    step("rst_start",     1,0,0,0,0, o(0,1,0,1,0,0,0));
    step("rst_wrdone",    0,0,0,1,0, o(1,0,0,1,0,0,0));
    #2 rst = 1'b0;
    #1 check_zero("async_reset_swap");
    @(negedge clk);
    rst = 1'b1;
    step("post_reset",    0,0,0,0,0, o(0,0,0,0,0,0,0));

`ifdef PINGPONG_SCHED_LOOP_LIMIT_EN
    loop_limit = 3;
    step("lim_start",     1,0,0,0,0, o(0,1,0,1,0,0,0));
    step("lim_wrdone",    0,0,0,1,0, o(1,0,0,1,0,0,0));
    step("lim_gap",       0,0,0,0,0, o(1,0,0,1,0,0,0));
    step("lim_run",       0,0,0,0,0, o(1,1,1,1,0,0,0));
    step("lim_fe1",       0,0,1,0,1, o(1,1,1,1,0,1,1));
    step("lim_fe2",       0,0,1,0,1, o(1,1,1,1,0,1,2));
    step("lim_fe3",       0,0,1,0,1, o(1,0,0,0,0,1,3));
`endif

    @(negedge clk);
    start = 0; stop = 0; repeat_mode = 0; wr_done = 0; frame_end = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
